// File: rtl/hazard_unit_pkg.sv
// Shared types for the data-hazard controller: instruction kinds,
// forwarding-select encodings and the "result late in EX" helper.
package hazard_unit_pkg;

    localparam int HZ_KIND_W = 2;
    localparam int FWD_SEL_W = 2;

    typedef enum logic [HZ_KIND_W-1:0] {
        HZ_KIND_ALU  = 2'd0,
        HZ_KIND_LOAD = 2'd1,
        HZ_KIND_MUL  = 2'd2,
        HZ_KIND_DIV  = 2'd3
    } hz_kind_e;

    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_SEL_RF  = 2'd0,
        FWD_SEL_EX  = 2'd1,
        FWD_SEL_MEM = 2'd2,
        FWD_SEL_WB  = 2'd3
    } fwd_sel_e;

    // Only ALU results exist at the end of EX; everything else needs more time.
    function automatic logic hz_late_in_ex(input hz_kind_e kind);
        return kind != HZ_KIND_ALU;
    endfunction

endpackage

// File: rtl/hazard_src_cmp.sv
// Per-operand hazard check: compares one ID source against the E/M/W
// shadow writers and returns the stall request and forwarding select.
module hazard_src_cmp
    import hazard_unit_pkg::*;
#(
    parameter int AW     = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [AW-1:0]        i_src,
    input  logic                 i_used,
    input  logic                 i_e_valid,
    input  logic                 i_e_we,
    input  logic [AW-1:0]        i_e_dest,
    input  hz_kind_e             i_e_kind,
    input  logic                 i_m_valid,
    input  logic                 i_m_we,
    input  logic [AW-1:0]        i_m_dest,
    input  hz_kind_e             i_m_kind,
    input  logic                 i_w_valid,
    input  logic                 i_w_we,
    input  logic [AW-1:0]        i_w_dest,
    input  logic                 i_ms_data_ok,
    output logic                 o_stall,
    output logic [FWD_SEL_W-1:0] o_fwd_sel
);

    logic     w_src_live;
    logic     w_e_hit;
    logic     w_m_hit;
    logic     w_w_hit;
    fwd_sel_e w_sel;

    // r0 is hard-wired zero, so it never depends on an in-flight writer.
    assign w_src_live = i_used && (i_src != '0);
    assign w_e_hit    = w_src_live && i_e_valid && i_e_we && (i_e_dest == i_src);
    assign w_m_hit    = w_src_live && i_m_valid && i_m_we && (i_m_dest == i_src);
    assign w_w_hit    = w_src_live && i_w_valid && i_w_we && (i_w_dest == i_src);

    // Nearest writer wins; stall only when the winning writer's value is not yet available.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        o_stall = 1'b0;
        w_sel   = FWD_SEL_RF;
        if (FWD_EN) begin
            if (w_e_hit) begin
                w_sel   = FWD_SEL_EX;
                o_stall = hz_late_in_ex(i_e_kind);
            end else if (w_m_hit) begin
                w_sel   = FWD_SEL_MEM;
                o_stall = (i_m_kind == HZ_KIND_LOAD) && !i_ms_data_ok;
            end else if (w_w_hit) begin
                w_sel   = FWD_SEL_WB;
            end
        end else begin
            o_stall = w_e_hit || w_m_hit || w_w_hit;
        end
    end

    assign o_fwd_sel = w_sel;

endmodule

// File: rtl/hazard_unit.sv
// Data-hazard controller beside ID: shadows the EX/MEM/WB writers, drives
// per-operand forwarding selects and the ID stall, and owns the divider busy counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int AW      = $clog2(NREG),
    parameter int NSRC    = 2,
    parameter bit FWD_EN  = 1'b1,
    parameter int DIV_LAT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ds_valid,
    input  logic [NSRC*AW-1:0]        ds_src_addr,
    input  logic [NSRC-1:0]           ds_src_used,
    input  logic [AW-1:0]             ds_dest,
    input  logic                      ds_we,
    input  logic [HZ_KIND_W-1:0]      ds_kind,
    input  logic                      ds_to_es_fire,
    input  logic                      es_to_ms_fire,
    input  logic                      ms_to_ws_fire,
    input  logic                      ws_retire,
    input  logic                      ms_data_ok,
    input  logic                      flush,
    output logic                      ds_stall,
    output logic [NSRC*FWD_SEL_W-1:0] fwd_sel,
    output logic                      es_busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    logic          r_e_valid;
    logic          r_e_we;
    logic [AW-1:0] r_e_dest;
    hz_kind_e      r_e_kind;
    logic          r_m_valid;
    logic          r_m_we;
    logic [AW-1:0] r_m_dest;
    hz_kind_e      r_m_kind;
    // Kind is not kept in W: a result that reached WB is always ready to forward.
    logic          r_w_valid;
    logic          r_w_we;
    logic [AW-1:0] r_w_dest;
    logic [CW-1:0] r_div_cnt;

    logic [NSRC-1:0] w_src_stall;

    // E and M shadows follow the fires; flush kills both and blocks same-cycle loads.
    always_ff @(posedge clk) begin
        // NOTE: only the valid bits are reset; dest/we/kind are ignored while valid is 0.
        if (reset || flush) begin
            r_e_valid <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking so M picks up the old E when both fires hit the same edge.
            if (ds_to_es_fire) begin
                r_e_valid <= 1'b1;
                r_e_we    <= ds_we;
                r_e_dest  <= ds_dest;
                r_e_kind  <= hz_kind_e'(ds_kind);
            end else if (es_to_ms_fire) begin
                r_e_valid <= 1'b0;
            end
            if (es_to_ms_fire) begin
                r_m_valid <= r_e_valid;
                r_m_we    <= r_e_we;
                r_m_dest  <= r_e_dest;
                r_m_kind  <= r_e_kind;
            end else if (ms_to_ws_fire) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    // W shadow advances from M or retires; flush does not touch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_valid <= 1'b0;
        end else if (ms_to_ws_fire) begin
            r_w_valid <= r_m_valid;
            r_w_we    <= r_m_we;
            r_w_dest  <= r_m_dest;
        end else if (ws_retire) begin
            r_w_valid <= 1'b0;
        end
    end

    // Divider occupancy: load on divide issue, count down to idle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_div_cnt <= '0;
        end else if (ds_to_es_fire && (hz_kind_e'(ds_kind) == HZ_KIND_DIV)) begin
            r_div_cnt <= CW'(DIV_LAT);
        end else if (r_div_cnt != '0) begin
            r_div_cnt <= r_div_cnt - CW'(1);
        end
    end

    assign es_busy = (r_div_cnt != '0);

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        hazard_src_cmp #(
            .AW     (AW),
            .FWD_EN (FWD_EN)
        ) u_cmp (
            .i_src        (ds_src_addr[g*AW +: AW]),
            .i_used       (ds_src_used[g]),
            .i_e_valid    (r_e_valid),
            .i_e_we       (r_e_we),
            .i_e_dest     (r_e_dest),
            .i_e_kind     (r_e_kind),
            .i_m_valid    (r_m_valid),
            .i_m_we       (r_m_we),
            .i_m_dest     (r_m_dest),
            .i_m_kind     (r_m_kind),
            .i_w_valid    (r_w_valid),
            .i_w_we       (r_w_we),
            .i_w_dest     (r_w_dest),
            .i_ms_data_ok (ms_data_ok),
            .o_stall      (w_src_stall[g]),
            .o_fwd_sel    (fwd_sel[g*FWD_SEL_W +: FWD_SEL_W])
        );
    end

    // Pure function of state and ID inputs: never loops back through the fire inputs.
    assign ds_stall = es_busy || (ds_valid && (|w_src_stall));

    // EX must hold while the divider is still working.
    a_no_ex_fire_while_busy : assert property (
        @(posedge clk) disable iff (reset) !(es_to_ms_fire && es_busy)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one forwarding build and one stall-only
// build share the same stimulus; expected values are hand-derived.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic       clk;
    logic       reset;
    logic       ds_valid;
    logic [9:0] ds_src_addr;
    logic [1:0] ds_src_used;
    logic [4:0] ds_dest;
    logic       ds_we;
    logic [1:0] ds_kind;
    logic       ds_to_es_fire;
    logic       es_to_ms_fire;
    logic       ms_to_ws_fire;
    logic       ws_retire;
    logic       ms_data_ok;
    logic       flush;
    logic       ds_stall;
    logic [3:0] fwd_sel;
    logic       es_busy;
    logic       ds_stall_nf;
    logic [3:0] fwd_sel_nf;
    logic       es_busy_nf;

    int n_cmp = 0;
    int n_err = 0;

    hazard_unit #(.FWD_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_src_addr(ds_src_addr),
        .ds_src_used(ds_src_used), .ds_dest(ds_dest), .ds_we(ds_we), .ds_kind(ds_kind),
        .ds_to_es_fire(ds_to_es_fire), .es_to_ms_fire(es_to_ms_fire),
        .ms_to_ws_fire(ms_to_ws_fire), .ws_retire(ws_retire), .ms_data_ok(ms_data_ok),
        .flush(flush), .ds_stall(ds_stall), .fwd_sel(fwd_sel), .es_busy(es_busy)
    );

    hazard_unit #(.FWD_EN(1'b0)) u_dut_nf (
        .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_src_addr(ds_src_addr),
        .ds_src_used(ds_src_used), .ds_dest(ds_dest), .ds_we(ds_we), .ds_kind(ds_kind),
        .ds_to_es_fire(ds_to_es_fire), .es_to_ms_fire(es_to_ms_fire),
        .ms_to_ws_fire(ms_to_ws_fire), .ws_retire(ws_retire), .ms_data_ok(ms_data_ok),
        .flush(flush), .ds_stall(ds_stall_nf), .fwd_sel(fwd_sel_nf), .es_busy(es_busy_nf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ds_valid      = 1'b0;
        ds_src_addr   = '0;
        ds_src_used   = '0;
        ds_dest       = '0;
        ds_we         = 1'b0;
        ds_kind       = HZ_KIND_ALU;
        ds_to_es_fire = 1'b0;
        es_to_ms_fire = 1'b0;
        ms_to_ws_fire = 1'b0;
        ws_retire     = 1'b0;
        ms_data_ok    = 1'b0;
        flush         = 1'b0;
    endtask

    // Present an instruction in ID (no fire).
    task automatic id_op(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic [4:0] dest, input logic [1:0] kind);
        ds_valid    = 1'b1;
        ds_src_addr = {s1, s0};
        ds_src_used = used;
        ds_dest     = dest;
        ds_we       = 1'b1;
        ds_kind     = kind;
    endtask

    // Flush E/M and retire W so the next scenario starts empty.
    task automatic drain();
        idle();
        flush     = 1'b1;
        ws_retire = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;

        // 1. Reset with random inputs: outputs stay quiet.
        for (int i = 0; i < 3; i++) begin
            tick();
            ds_valid      = 1'($urandom);
            ds_src_addr   = 10'($urandom);
            ds_src_used   = 2'($urandom);
            ds_dest       = 5'($urandom);
            ds_we         = 1'($urandom);
            ds_kind       = 2'($urandom);
            ds_to_es_fire = 1'($urandom);
            es_to_ms_fire = 1'($urandom);
            ms_to_ws_fire = 1'($urandom);
            ws_retire     = 1'($urandom);
            ms_data_ok    = 1'($urandom);
            flush         = 1'($urandom);
            #1;
            check("rst_stall", ds_stall, 0);
            check("rst_fwd", fwd_sel, 0);
            check("rst_busy", es_busy, 0);
        end
        reset = 1'b0;
        idle();
        tick();

        // 2. Load-use: ld.w r5 in EX, then add reading r5.
        id_op(5'd0, 5'd0, 2'b00, 5'd5, HZ_KIND_LOAD);
        ds_to_es_fire = 1'b1;
        tick();
        ds_to_es_fire = 1'b0;
        id_op(5'd5, 5'd0, 2'b01, 5'd6, HZ_KIND_ALU);
        #1;
        check("ld_ex_stall", ds_stall, 1);
        check("ld_ex_fwd", fwd_sel[1:0], FWD_SEL_EX);
        es_to_ms_fire = 1'b1;
        ms_data_ok    = 1'b1;
        tick();
        es_to_ms_fire = 1'b0;
        #1;
        check("ld_mem_ok_stall", ds_stall, 0);
        check("ld_mem_ok_fwd", fwd_sel[1:0], FWD_SEL_MEM);
        check("nf_mem_stall", ds_stall_nf, 1);
        ms_data_ok = 1'b0;
        #1;
        check("ld_mem_wait_stall", ds_stall, 1);
        ms_to_ws_fire = 1'b1;
        tick();
        ms_to_ws_fire = 1'b0;
        #1;
        check("ld_wb_fwd", fwd_sel[1:0], FWD_SEL_WB);
        check("ld_wb_stall", ds_stall, 0);
        check("nf_wb_stall", ds_stall_nf, 1);
        check("nf_wb_fwd", fwd_sel_nf, 0);
        ws_retire = 1'b1;
        tick();
        ws_retire = 1'b0;
        #1;
        check("retired_fwd", fwd_sel, 0);
        check("nf_retired_stall", ds_stall_nf, 0);
        drain();

        // 3. r7 in EX and (older) r7 in MEM: EX wins for src1.
        id_op(5'd0, 5'd0, 2'b00, 5'd7, HZ_KIND_ALU);
        ds_to_es_fire = 1'b1;
        tick();
        es_to_ms_fire = 1'b1;
        tick();
        ds_to_es_fire = 1'b0;
        es_to_ms_fire = 1'b0;
        id_op(5'd3, 5'd7, 2'b11, 5'd8, HZ_KIND_ALU);
        #1;
        check("ex_wins_fwd", fwd_sel, 4'b0100);
        check("ex_wins_stall", ds_stall, 0);
        check("nf_ex_stall", ds_stall_nf, 1);
        es_to_ms_fire = 1'b1;
        ms_to_ws_fire = 1'b1;
        tick();
        es_to_ms_fire = 1'b0;
        ms_to_ws_fire = 1'b0;
        #1;
        check("mem_wins_fwd", fwd_sel, 4'b1000);
        check("mem_alu_stall", ds_stall, 0);
        drain();

        // 4. Divide occupies EX for exactly DIV_LAT cycles.
        id_op(5'd0, 5'd0, 2'b00, 5'd9, HZ_KIND_DIV);
        ds_to_es_fire = 1'b1;
        tick();
        ds_to_es_fire = 1'b0;
        id_op(5'd1, 5'd0, 2'b01, 5'd2, HZ_KIND_ALU);
        #1;
        for (int i = 0; i < 16; i++) begin
            check("div_busy", es_busy, 1);
            check("div_stall", ds_stall, 1);
            tick();
        end
        check("div_done_busy", es_busy, 0);
        check("div_done_stall", ds_stall, 0);
        check("nf_div_done_busy", es_busy_nf, 0);
        drain();

        // 5. r0 writers in every stage never create a hazard.
        id_op(5'd0, 5'd0, 2'b00, 5'd0, HZ_KIND_LOAD);
        ds_to_es_fire = 1'b1;
        tick();
        es_to_ms_fire = 1'b1;
        tick();
        ms_to_ws_fire = 1'b1;
        tick();
        ds_to_es_fire = 1'b0;
        es_to_ms_fire = 1'b0;
        ms_to_ws_fire = 1'b0;
        id_op(5'd0, 5'd0, 2'b11, 5'd4, HZ_KIND_ALU);
        #1;
        check("r0_stall", ds_stall, 0);
        check("r0_fwd", fwd_sel, 0);
        check("nf_r0_stall", ds_stall_nf, 0);
        drain();

        // 6. Flush with a load in EX and the divider counting.
        id_op(5'd0, 5'd0, 2'b00, 5'd9, HZ_KIND_DIV);
        ds_to_es_fire = 1'b1;
        tick();
        id_op(5'd0, 5'd0, 2'b00, 5'd5, HZ_KIND_LOAD);
        tick();
        ds_to_es_fire = 1'b0;
        id_op(5'd5, 5'd0, 2'b01, 5'd6, HZ_KIND_ALU);
        #1;
        check("pre_flush_busy", es_busy, 1);
        check("pre_flush_stall", ds_stall, 1);
        check("pre_flush_fwd", fwd_sel[1:0], FWD_SEL_EX);
        flush         = 1'b1;
        ds_to_es_fire = 1'b1;
        ds_dest       = 5'd5;
        ds_kind       = HZ_KIND_LOAD;
        tick();
        flush         = 1'b0;
        ds_to_es_fire = 1'b0;
        id_op(5'd5, 5'd0, 2'b01, 5'd6, HZ_KIND_ALU);
        #1;
        check("post_flush_busy", es_busy, 0);
        check("post_flush_stall", ds_stall, 0);
        check("post_flush_fwd", fwd_sel, 0);
        check("nf_post_flush_stall", ds_stall_nf, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
